// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, drives a req/ack
// instruction memory and presents one instruction at a time to decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [31:0]       im_rdata,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_instr,
    output logic [31:0]       fetch_pc,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        VALID,
        HALT
    } state_t;

    state_t            state;
    logic              squash;
    logic              do_issue;
    logic              legal;
    logic [31:0]       next_pc;
    logic [31:0]       off;
    logic [ADDR_W-1:0] next_idx;

    // Address used by an issue this cycle: a redirect always wins.
    always_comb begin
        next_pc  = redirect_valid ? redirect_pc : fetch_pc;
        off      = next_pc - RESET_PC;
        legal    = (next_pc[1:0] == 2'b00)
                && (next_pc >= RESET_PC)
                && ((off[31:2] >> ADDR_W) == '0);
        next_idx = off[ADDR_W+1:2];
    end

    always_comb begin
        do_issue = 1'b0;
        unique case (state)
            BOOT:  do_issue = 1'b1;
            FETCH: do_issue = im_ack && (squash || redirect_valid);
            VALID: do_issue = redirect_valid || !stall;
            HALT:  do_issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            if_pc    <= RESET_PC;
            if_instr <= '0;
            if_valid <= 1'b0;
            im_req   <= 1'b0;
            im_addr  <= '0;
            addr_err <= 1'b0;
            squash   <= 1'b0;
        end else begin
            unique case (state)
                BOOT: ;
                FETCH: begin
                    if (im_ack) begin
                        squash <= 1'b0;
                        if (!squash && !redirect_valid) begin
                            if_instr <= im_rdata;
                            if_pc    <= fetch_pc;
                            fetch_pc <= fetch_pc + 32'd4;
                            if_valid <= 1'b1;
                            im_req   <= 1'b0;
                            state    <= VALID;
                        end
                    end else if (redirect_valid) begin
                        // Request stays in flight; its data will be dropped.
                        fetch_pc <= redirect_pc;
                        squash   <= 1'b1;
                    end
                end
                VALID: begin
                    if (do_issue) begin
                        if_valid <= 1'b0;
                    end
                end
                HALT: ;
            endcase

            if (do_issue) begin
                fetch_pc <= next_pc;
                if (legal) begin
                    state   <= FETCH;
                    im_req  <= 1'b1;
                    im_addr <= next_idx;
                end else begin
                    state    <= HALT;
                    im_req   <= 1'b0;
                    addr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed steps plus a randomized
// phase checked against a stream-level model of consumed instructions.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          ADDR_W   = 10;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_ack;
    logic [31:0]       im_rdata;
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_instr;
    logic [31:0]       fetch_pc;
    logic              addr_err;

    fetch_sequencer #(
        .RESET_PC(RESET_PC),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .im_req        (im_req),
        .im_addr       (im_addr),
        .im_ack        (im_ack),
        .im_rdata      (im_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .fetch_pc      (fetch_pc),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int          errors = 0;
    int          checks = 0;
    int          cons   = 0;
    logic [31:0] exp_pc;
    bit          pend;
    int          cnt;
    int          lat;
    int          fix_lat;
    bit          rand_lat;

    function automatic logic [ADDR_W-1:0] idx_of(input logic [31:0] pc);
        logic [31:0] o;
        o = pc - RESET_PC;
        return o[ADDR_W+1:2];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score the edge just about to happen, then model memory.
    task automatic tick();
        logic              consume;
        logic              hold;
        logic              pending;
        logic [31:0]       hpc;
        logic [31:0]       hin;
        logic [ADDR_W-1:0] haddr;
        consume = if_valid && !stall && !redirect_valid;
        hold    = if_valid && stall && !redirect_valid;
        pending = im_req && !im_ack;
        hpc     = if_pc;
        hin     = if_instr;
        haddr   = im_addr;
        if (consume) begin
            chk("consume_pc", if_pc, exp_pc);
            chk("consume_instr", if_instr, mem[idx_of(exp_pc)]);
            exp_pc = exp_pc + 32'd4;
            cons++;
        end
        if (redirect_valid && !addr_err) exp_pc = redirect_pc;
        @(posedge clk);
        #1;
        chk("req_and_valid", {31'd0, im_req && if_valid}, 32'd0);
        if (hold) begin
            chk("hold_valid", {31'd0, if_valid}, 32'd1);
            chk("hold_pc", if_pc, hpc);
            chk("hold_instr", if_instr, hin);
            chk("hold_req", {31'd0, im_req}, 32'd0);
        end
        if (pending) begin
            chk("req_stable", {31'd0, im_req}, 32'd1);
            chk("addr_stable", {22'd0, im_addr}, {22'd0, haddr});
        end
        if (!im_req) begin
            pend   = 1'b0;
            im_ack = 1'b0;
        end else begin
            if (!pend) begin
                pend = 1'b1;
                cnt  = 0;
                lat  = rand_lat ? int'($urandom_range(1, 4)) : fix_lat;
            end
            cnt++;
            if (cnt >= lat) begin
                im_ack   = 1'b1;
                im_rdata = mem[im_addr];
                pend     = 1'b0;
            end else begin
                im_ack   = 1'b0;
                im_rdata = $urandom;
            end
        end
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        while (!if_valid && n < maxc) begin
            tick();
            n++;
        end
        chk("valid_timeout", {31'd0, if_valid}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        chk("rst_req", {31'd0, im_req}, 32'd0);
        chk("rst_fetch_pc", fetch_pc, RESET_PC);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        exp_pc = RESET_PC;
        pend   = 1'b0;
        im_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bad [3];
        int          c0;
        int          n;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        mem[0] = 32'h3C01_0001;
        mem[1] = 32'h3421_0002;
        bad[0] = 32'h0000_3002;
        bad[1] = 32'h0000_2FFC;
        bad[2] = 32'h0000_4000;

        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        im_ack         = 1'b0;
        im_rdata       = '0;
        pend           = 1'b0;
        fix_lat        = 1;
        rand_lat       = 1'b0;
        exp_pc         = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", {31'd0, im_req}, 32'd0);
        chk("reset_addr", {22'd0, im_addr}, 32'd0);
        chk("reset_valid", {31'd0, if_valid}, 32'd0);
        chk("reset_if_pc", if_pc, RESET_PC);
        chk("reset_instr", if_instr, 32'd0);
        chk("reset_fetch_pc", fetch_pc, RESET_PC);
        chk("reset_err", {31'd0, addr_err}, 32'd0);
        reset = 1'b0;

        // Boot cycle, then two back-to-back fetches at latency 1.
        chk("boot_idle", {31'd0, im_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, im_req}, 32'd1);
        chk("first_addr", {22'd0, im_addr}, 32'd0);
        tick();
        chk("i0_valid", {31'd0, if_valid}, 32'd1);
        chk("i0_pc", if_pc, 32'h0000_3000);
        chk("i0_instr", if_instr, 32'h3C01_0001);
        tick();
        chk("i1_addr", {22'd0, im_addr}, 32'd1);
        tick();
        chk("i1_pc", if_pc, 32'h0000_3004);
        chk("i1_instr", if_instr, 32'h3421_0002);
        chk("i1_fetch_pc", fetch_pc, 32'h0000_3008);

        // Decode stall holds the presented instruction.
        stall = 1'b1;
        repeat (5) begin
            tick();
            chk("stall_req", {31'd0, im_req}, 32'd0);
            chk("stall_pc", if_pc, 32'h0000_3004);
        end
        stall = 1'b0;
        tick();
        chk("post_stall_req", {31'd0, im_req}, 32'd1);
        chk("post_stall_addr", {22'd0, im_addr}, 32'd2);
        tick();

        // Redirect during a slow fetch: old data dropped.
        fix_lat = 3;
        tick();
        chk("slow_addr", {22'd0, im_addr}, 32'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3040;
        tick();
        redirect_valid = 1'b0;
        chk("sq_fetch_pc", fetch_pc, 32'h0000_3040);
        chk("sq_addr_hold", {22'd0, im_addr}, 32'd3);
        tick();
        chk("sq_addr_hold2", {22'd0, im_addr}, 32'd3);
        chk("sq_no_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("sq_no_valid2", {31'd0, if_valid}, 32'd0);
        chk("sq_reissue_req", {31'd0, im_req}, 32'd1);
        chk("sq_reissue_addr", {22'd0, im_addr}, 32'h10);
        wait_valid(10);
        chk("sq_if_pc", if_pc, 32'h0000_3040);

        // Redirect coincident with ack.
        fix_lat = 2;
        tick();
        n = 0;
        while (!im_ack && n < 10) begin
            tick();
            n++;
        end
        chk("ack_seen", {31'd0, im_ack}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3100;
        tick();
        redirect_valid = 1'b0;
        chk("ackred_valid", {31'd0, if_valid}, 32'd0);
        chk("ackred_req", {31'd0, im_req}, 32'd1);
        chk("ackred_addr", {22'd0, im_addr}, 32'h40);
        chk("ackred_fetch_pc", fetch_pc, 32'h0000_3100);
        wait_valid(10);
        chk("ackred_if_pc", if_pc, 32'h0000_3100);

        // Redirect beats stall in VALID.
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3200;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        chk("rs_valid", {31'd0, if_valid}, 32'd0);
        chk("rs_req", {31'd0, im_req}, 32'd1);
        chk("rs_addr", {22'd0, im_addr}, 32'h80);
        wait_valid(10);
        chk("rs_if_pc", if_pc, 32'h0000_3200);

        // Randomized traffic against the stream model.
        rand_lat = 1'b1;
        c0       = cons;
        repeat (400) begin
            stall          = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = RESET_PC + 32'($urandom_range(0, 511)) * 4;
            tick();
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        chk("random_progress", {31'd0, (cons - c0) > 20}, 32'd1);
        rand_lat = 1'b0;
        fix_lat  = 1;

        // Illegal redirect targets halt until reset.
        for (int k = 0; k < 3; k++) begin
            wait_valid(10);
            redirect_valid = 1'b1;
            redirect_pc    = bad[k];
            tick();
            redirect_valid = 1'b0;
            chk("halt_err", {31'd0, addr_err}, 32'd1);
            chk("halt_req", {31'd0, im_req}, 32'd0);
            chk("halt_valid", {31'd0, if_valid}, 32'd0);
            redirect_valid = 1'b1;
            redirect_pc    = RESET_PC;
            tick();
            redirect_valid = 1'b0;
            tick();
            chk("halt_sticky", {31'd0, addr_err}, 32'd1);
            chk("halt_req2", {31'd0, im_req}, 32'd0);
            chk("halt_valid2", {31'd0, if_valid}, 32'd0);
            do_reset();
        end

        // Boot redirect to the last word; sequential run-off halts.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3FFC;
        tick();
        redirect_valid = 1'b0;
        chk("boot_red_req", {31'd0, im_req}, 32'd1);
        chk("boot_red_addr", {22'd0, im_addr}, 32'h3FF);
        chk("boot_red_err", {31'd0, addr_err}, 32'd0);
        wait_valid(10);
        chk("last_if_pc", if_pc, 32'h0000_3FFC);
        tick();
        chk("runoff_err", {31'd0, addr_err}, 32'd1);
        chk("runoff_req", {31'd0, im_req}, 32'd0);
        chk("runoff_fetch_pc", fetch_pc, 32'h0000_4000);
        do_reset();

        // Reset in the middle of a pending fetch.
        fix_lat = 4;
        tick();
        tick();
        chk("mid_pending", {31'd0, im_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_req", {31'd0, im_req}, 32'd0);
        chk("mid_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_addr", {22'd0, im_addr}, 32'd0);
        chk("mid_fetch_pc", fetch_pc, RESET_PC);
        chk("mid_if_pc", if_pc, RESET_PC);
        chk("mid_instr", if_instr, 32'd0);
        im_ack   = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        chk("late_ack_rst", {31'd0, if_valid}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("late_ack_boot", {31'd0, if_valid}, 32'd0);
        chk("late_req", {31'd0, im_req}, 32'd1);
        chk("late_addr", {22'd0, im_addr}, 32'd0);
        im_ack  = 1'b0;
        pend    = 1'b0;
        exp_pc  = RESET_PC;
        fix_lat = 1;
        wait_valid(10);
        chk("resume_pc", if_pc, RESET_PC);
        chk("resume_instr", if_instr, 32'h3C01_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
